// File: rtl/tlc_lamp_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tlc_pkg
//  Brief    : Shared light encodings, fault codes and monitor state type for
//             the traffic-light lamp monitor.
//  Revision : 1.0 - initial release
// ============================================================================
package tlc_pkg;

  // One-hot lamp codes: bit2 red, bit1 yellow, bit0 green
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_OFF    = 3'b000;

  // Fault codes, listed in decreasing priority after FLT_NONE
  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b01;
  localparam logic [1:0] FLT_CONFLICT = 2'b10;
  localparam logic [1:0] FLT_YELLOW   = 2'b11;

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    FLASH   = 2'd1,
    RECOVER = 2'd2
  } mon_state_t;

  // A code is legal only when exactly one lamp is lit
  function automatic logic is_one_hot(input logic [2:0] l);
    return (l == LIGHT_RED) || (l == LIGHT_YELLOW) || (l == LIGHT_GREEN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlc_lamp_monitor_approach_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tlc_approach_tracker
//  Brief    : Per-approach history (previous code, yellow run length) and
//             combinational legality / right-of-way / yellow-phase checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tlc_approach_tracker
  import tlc_pkg::*;
#(
  parameter int MIN_YELLOW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  input  logic       load,
  output logic       legal,
  output logic       not_red,
  output logic       yellow_viol
);

  localparam int YW = $clog2(MIN_YELLOW + 1);
  localparam logic [YW-1:0] YSAT = YW'(MIN_YELLOW);

  logic [2:0]    prev;
  logic [YW-1:0] ycnt;

  assign legal   = is_one_hot(light);
  assign not_red = (light != LIGHT_RED);

  // Short yellow, yellow straight back to green, or green straight to red
  always_comb begin
    yellow_viol = 1'b0;
    if (prev == LIGHT_YELLOW && light != LIGHT_YELLOW && ycnt < YSAT)
      yellow_viol = 1'b1;
    if (prev == LIGHT_YELLOW && light == LIGHT_GREEN)
      yellow_viol = 1'b1;
    if (prev == LIGHT_GREEN && light == LIGHT_RED)
      yellow_viol = 1'b1;
  end

  // History update; load reseeds from the live code with a full yellow count
  // so that returning to service mid-yellow cannot raise a false fault
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= LIGHT_RED;
      ycnt <= YSAT;
    end else if (load) begin
      prev <= light;
      ycnt <= YSAT;
    end else begin
      prev <= light;
      if (light == LIGHT_YELLOW) begin
        if (prev != LIGHT_YELLOW)
          ycnt <= YW'(1);
        else if (ycnt < YSAT)
          ycnt <= ycnt + YW'(1);
      end else begin
        ycnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlc_lamp_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tlc_lamp_monitor
//  Brief    : Safety stage between the controller FSM and the lamp drivers.
//             Forwards lamp codes with one cycle of latency, latches faults
//             and drives flashing all-red until cleared and recovered.
//             Optional macro TLC_MON_STATS_EN adds a saturating fault_count.
//  Revision : 1.0 - initial release
// ============================================================================
module tlc_lamp_monitor
  import tlc_pkg::*;
#(
  parameter int FLASH_HALF = 4,
  parameter int MIN_YELLOW = 4,
  parameter int ALLRED_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] north_light,
  input  logic [2:0] east_light,
  input  logic [2:0] south_light,
  input  logic [2:0] west_light,
  input  logic       fault_clr,
  output logic [2:0] lamp_n,
  output logic [2:0] lamp_e,
  output logic [2:0] lamp_s,
  output logic [2:0] lamp_w,
  output logic       fault,
  output logic [1:0] fault_code
`ifdef TLC_MON_STATS_EN
  ,
  output logic [7:0] fault_count
`endif
);

  mon_state_t state;
  logic [7:0] cnt;
  logic       flash_on;

  logic [2:0] light_in [4];
  logic [3:0] legal;
  logic [3:0] not_red;
  logic [3:0] yviol;
  logic       load;

  logic       illegal;
  logic       conflict;
  logic       hard_fault;
  logic [1:0] hard_code;
  logic       yellow_fault;
  logic       enter_flash;

  assign light_in[0] = north_light;
  assign light_in[1] = east_light;
  assign light_in[2] = south_light;
  assign light_in[3] = west_light;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_trk
      tlc_approach_tracker #(
        .MIN_YELLOW (MIN_YELLOW)
      ) u_trk (
        .clk         (clk),
        .rst         (rst),
        .light       (light_in[i]),
        .load        (load),
        .legal       (legal[i]),
        .not_red     (not_red[i]),
        .yellow_viol (yviol[i])
      );
    end
  endgenerate

  // Illegal and conflict checks are live in every state; yellow only matters in NORMAL
  always_comb begin
    logic [2:0] nr_sum;
    nr_sum       = {2'b00, not_red[0]} + {2'b00, not_red[1]}
                 + {2'b00, not_red[2]} + {2'b00, not_red[3]};
    illegal      = ~&legal;
    conflict     = (nr_sum >= 3'd2);
    hard_fault   = illegal | conflict;
    hard_code    = illegal ? FLT_ILLEGAL : FLT_CONFLICT;
    yellow_fault = |yviol;
  end

  // History reload happens on the clean edge that ends the all-red interval
  assign load = (state == RECOVER) && !hard_fault && (cnt == 8'(ALLRED_CYC - 1));

  assign enter_flash = ((state == NORMAL) && (hard_fault || yellow_fault)) ||
                       ((state == RECOVER) && hard_fault);

  // Monitor FSM with registered lamp drive and fault outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= NORMAL;
      cnt        <= '0;
      flash_on   <= 1'b1;
      lamp_n     <= LIGHT_RED;
      lamp_e     <= LIGHT_RED;
      lamp_s     <= LIGHT_RED;
      lamp_w     <= LIGHT_RED;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
    end else begin
      case (state)
        NORMAL: begin
          if (hard_fault || yellow_fault) begin
            // Offending code is replaced by all-red at the same edge
            lamp_n     <= LIGHT_RED;
            lamp_e     <= LIGHT_RED;
            lamp_s     <= LIGHT_RED;
            lamp_w     <= LIGHT_RED;
            fault      <= 1'b1;
            fault_code <= hard_fault ? hard_code : FLT_YELLOW;
            state      <= FLASH;
            cnt        <= '0;
            flash_on   <= 1'b1;
          end else begin
            lamp_n <= north_light;
            lamp_e <= east_light;
            lamp_s <= south_light;
            lamp_w <= west_light;
          end
        end
        FLASH: begin
          if (fault_clr && !hard_fault) begin
            lamp_n <= LIGHT_RED;
            lamp_e <= LIGHT_RED;
            lamp_s <= LIGHT_RED;
            lamp_w <= LIGHT_RED;
            state  <= RECOVER;
            cnt    <= '0;
          end else if (cnt == 8'(FLASH_HALF - 1)) begin
            cnt      <= '0;
            flash_on <= ~flash_on;
            lamp_n   <= flash_on ? LIGHT_OFF : LIGHT_RED;
            lamp_e   <= flash_on ? LIGHT_OFF : LIGHT_RED;
            lamp_s   <= flash_on ? LIGHT_OFF : LIGHT_RED;
            lamp_w   <= flash_on ? LIGHT_OFF : LIGHT_RED;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RECOVER: begin
          if (hard_fault) begin
            fault_code <= hard_code;
            state      <= FLASH;
            cnt        <= '0;
            flash_on   <= 1'b1;
          end else if (cnt == 8'(ALLRED_CYC - 1)) begin
            // Lamps stay red on this edge and follow inputs from the next
            state      <= NORMAL;
            fault      <= 1'b0;
            fault_code <= FLT_NONE;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= NORMAL;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef TLC_MON_STATS_EN
  // Saturating count of every entry into flashing
  always_ff @(posedge clk) begin
    if (rst)
      fault_count <= 8'd0;
    else if (enter_flash && fault_count != 8'hFF)
      fault_count <= fault_count + 8'd1;
  end
`else
  logic unused_enter_flash;
  assign unused_enter_flash = enter_flash;
`endif

endmodule
`default_nettype wire
